// File: rtl/dm_sb_arbiter.sv
// Purpose : two-requester arbiter in front of one shared system bus (port 0 = SBA, port 1 = abstract-command memory).
// Latency : zero-cycle request/grant pass-through; response forwarded in the same cycle it arrives, or error after TimeoutCycles.
// Backpr. : requester holds req + payload until gnt; one transaction outstanding, further requests stall while waiting.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   m0_* / m1_*                requester ports: req/we/add/wdata/be in, gnt/r_valid/r_err/r_rdata out
//   master_*                   shared downstream bus: req/we/add/wdata/be out, gnt/r_valid/r_rdata in
//   busy_o                     arbiter is not idle
// Build option: define DM_SB_ARBITER_RR_EN for round-robin arbitration (default is fixed priority, port 0 first).

module dm_sb_arbiter #(
    parameter int BusWidth      = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [BusWidth-1:0]   m0_add_i,
    input  logic [BusWidth-1:0]   m0_wdata_i,
    input  logic [BusWidth/8-1:0] m0_be_i,
    output logic                  m0_gnt_o,
    output logic                  m0_r_valid_o,
    output logic                  m0_r_err_o,
    output logic [BusWidth-1:0]   m0_r_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [BusWidth-1:0]   m1_add_i,
    input  logic [BusWidth-1:0]   m1_wdata_i,
    input  logic [BusWidth/8-1:0] m1_be_i,
    output logic                  m1_gnt_o,
    output logic                  m1_r_valid_o,
    output logic                  m1_r_err_o,
    output logic [BusWidth-1:0]   m1_r_rdata_o,

    output logic                  master_req_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i,

    output logic                  busy_o
);

    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Req  = 2'd1,
        Wait = 2'd2
    } state_e;

    state_e          state;
    logic            owner;
    logic [CntW-1:0] cnt;

    logic any_req;
    logic winner;
    logic sel;
    logic sel_req;
    logic grant;
    logic timeout_hit;
    logic resp_ok;
    logic resp_err;
    logic resp_vld;

    assign any_req = m0_req_i | m1_req_i;

`ifdef DM_SB_ARBITER_RR_EN
    // Preferred port; after every grant it points at the port that lost.
    logic ptr;
    assign winner = (m0_req_i && m1_req_i) ? ptr : m1_req_i;
`else
    assign winner = m1_req_i && !m0_req_i;
`endif

    // Once a port is selected it stays selected until granted or withdrawn,
    // so the downstream bus never sees the payload change under a stall.
    assign sel     = (state == Idle) ? winner : owner;
    assign sel_req = sel ? m1_req_i : m0_req_i;

    always_comb begin
        master_req_o   = 1'b0;
        master_we_o    = 1'b0;
        master_add_o   = '0;
        master_wdata_o = '0;
        master_be_o    = '0;
        if (!rst_i && state != Wait && (state == Req || any_req)) begin
            master_req_o   = sel_req;
            master_we_o    = sel ? m1_we_i    : m0_we_i;
            master_add_o   = sel ? m1_add_i   : m0_add_i;
            master_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
            master_be_o    = sel ? m1_be_i    : m0_be_i;
        end
    end

    assign grant = master_req_o && master_gnt_i;

    // A real response beats a coinciding timeout.
    assign timeout_hit = (TimeoutCycles != 0) && (cnt == CntLimit);
    assign resp_ok     = !rst_i && (state == Wait) && master_r_valid_i;
    assign resp_err    = !rst_i && (state == Wait) && !master_r_valid_i && timeout_hit;
    assign resp_vld    = resp_ok || resp_err;

    assign m0_gnt_o     = grant && !sel;
    assign m1_gnt_o     = grant && sel;
    assign m0_r_valid_o = resp_vld && !owner;
    assign m1_r_valid_o = resp_vld && owner;
    assign m0_r_err_o   = resp_err && !owner;
    assign m1_r_err_o   = resp_err && owner;
    assign m0_r_rdata_o = (resp_err && !owner) ? '0 : master_r_rdata_i;
    assign m1_r_rdata_o = (resp_err && owner)  ? '0 : master_r_rdata_i;

    assign busy_o = (state != Idle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= Idle;
            owner <= 1'b0;
            cnt   <= '0;
`ifdef DM_SB_ARBITER_RR_EN
            ptr   <= 1'b0;
`endif
        end else begin
            case (state)
                Idle: begin
                    if (any_req) begin
                        owner <= winner;
                        if (master_gnt_i) begin
                            state <= Wait;
                            cnt   <= '0;
                        end else begin
                            state <= Req;
                        end
                    end
                end
                Req: begin
                    if (!sel_req) begin
                        state <= Idle;
                    end else if (master_gnt_i) begin
                        state <= Wait;
                        cnt   <= '0;
                    end
                end
                Wait: begin
                    if (resp_vld) begin
                        state <= Idle;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                default: state <= Idle;
            endcase
`ifdef DM_SB_ARBITER_RR_EN
            if (grant) begin
                ptr <= ~sel;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dm_sb_arbiter.sv
// Purpose : randomized bench for dm_sb_arbiter against a transaction-level reference model.
// Latency : checks every cycle on the falling edge; inputs change 1 time unit after the rising edge.
// Backpr. : requesters hold requests until granted, occasionally withdraw; downstream gnt/r_valid are random.

module tb_dm_sb_arbiter;

    localparam int BW = 32;
    localparam int TO = 4;
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] add   [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        m_gnt, m_rvld;
    logic [31:0] m_rdata;

    logic        m0_gnt, m0_rvld, m0_rerr, m1_gnt, m1_rvld, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mst_req, mst_we, busy;
    logic [31:0] mst_add, mst_wdata;
    logic [3:0]  mst_be;

    dm_sb_arbiter #(.BusWidth(BW), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_add_i(add[0]), .m0_wdata_i(wdata[0]), .m0_be_i(be[0]),
        .m0_gnt_o(m0_gnt), .m0_r_valid_o(m0_rvld), .m0_r_err_o(m0_rerr), .m0_r_rdata_o(m0_rdata),
        .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_add_i(add[1]), .m1_wdata_i(wdata[1]), .m1_be_i(be[1]),
        .m1_gnt_o(m1_gnt), .m1_r_valid_o(m1_rvld), .m1_r_err_o(m1_rerr), .m1_r_rdata_o(m1_rdata),
        .master_req_o(mst_req), .master_we_o(mst_we), .master_add_o(mst_add),
        .master_wdata_o(mst_wdata), .master_be_o(mst_be),
        .master_gnt_i(m_gnt), .master_r_valid_i(m_rvld), .master_r_rdata_i(m_rdata),
        .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: which port is presented but not yet granted (-1 none),
    // which port awaits its response (-1 none), and how long it has waited.
    int presented;
    int outstanding;
    int waited;
`ifdef DM_SB_ARBITER_RR_EN
    int preferred;
`endif
    bit granted [2];

    task automatic model_reset();
        presented   = -1;
        outstanding = -1;
        waited      = 0;
`ifdef DM_SB_ARBITER_RR_EN
        preferred   = 0;
`endif
        granted[0]  = 1'b0;
        granted[1]  = 1'b0;
    endtask

    task automatic note_grant(input int p);
        granted[p]  = 1'b1;
        outstanding = p;
        waited      = 0;
        presented   = -1;
`ifdef DM_SB_ARBITER_RR_EN
        preferred   = 1 - p;
`endif
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model.
    task automatic evaluate();
        bit          e_gnt [2];
        bit          e_vld [2];
        bit          e_err [2];
        logic [31:0] e_rd  [2];
        bit          e_busy, e_mreq, pay_known;
        int          show;
        int          o;
        e_gnt = '{1'b0, 1'b0};
        e_vld = '{1'b0, 1'b0};
        e_err = '{1'b0, 1'b0};
        e_rd[0] = m_rdata;
        e_rd[1] = m_rdata;
        e_busy = 1'b0;
        e_mreq = 1'b0;
        pay_known = 1'b0;
        show = -1;
        granted[0] = 1'b0;
        granted[1] = 1'b0;

        if (rst) begin
            model_reset();
            return;
        end

        if (outstanding >= 0) begin
            o = outstanding;
            e_busy = 1'b1;
            if (m_rvld) begin
                e_vld[o] = 1'b1;
            end else if (TO > 0 && waited == TO) begin
                e_vld[o] = 1'b1;
                e_err[o] = 1'b1;
                e_rd[o]  = 32'h0;
            end
            if (e_vld[o]) outstanding = -1;
            else          waited++;
        end else if (presented >= 0) begin
            e_busy = 1'b1;
            show   = presented;
            e_mreq = req[presented];
            if (!req[presented]) begin
                presented = -1;
            end else if (m_gnt) begin
                e_gnt[presented] = 1'b1;
                note_grant(presented);
            end
        end else begin
            pay_known = 1'b1;
            if (req[0] || req[1]) begin
`ifdef DM_SB_ARBITER_RR_EN
                show = (req[0] && req[1]) ? preferred : (req[1] ? 1 : 0);
`else
                show = req[0] ? 0 : 1;
`endif
                e_mreq = 1'b1;
                if (m_gnt) begin
                    e_gnt[show] = 1'b1;
                    note_grant(show);
                end else begin
                    presented = show;
                end
            end
        end

        check_eq("busy",     busy,     e_busy);
        check_eq("m0_gnt",   m0_gnt,   e_gnt[0]);
        check_eq("m1_gnt",   m1_gnt,   e_gnt[1]);
        check_eq("m0_rvld",  m0_rvld,  e_vld[0]);
        check_eq("m1_rvld",  m1_rvld,  e_vld[1]);
        check_eq("m0_rdata", m0_rdata, e_rd[0]);
        check_eq("m1_rdata", m1_rdata, e_rd[1]);
        if (e_vld[0]) check_eq("m0_rerr", m0_rerr, e_err[0]);
        if (e_vld[1]) check_eq("m1_rerr", m1_rerr, e_err[1]);
        check_eq("mst_req", mst_req, e_mreq);
        if (show >= 0) begin
            check_eq("mst_add",   mst_add,   add[show]);
            check_eq("mst_wdata", mst_wdata, wdata[show]);
            check_eq("mst_be",    mst_be,    be[show]);
            check_eq("mst_we",    mst_we,    we[show]);
        end else if (pay_known) begin
            check_eq("mst_add_idle",   mst_add,   32'h0);
            check_eq("mst_wdata_idle", mst_wdata, 32'h0);
            check_eq("mst_be_idle",    mst_be,    4'h0);
        end
    endtask

    task automatic new_payload(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        add[p]   = $urandom;
        wdata[p] = $urandom;
        be[p]    = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_next();
        if (rst) begin
            rst = 1'b0;
        end else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            req[0] = 1'b0;
            req[1] = 1'b0;
        end
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && granted[p]) begin
                    if ($urandom_range(0, 1) == 0) new_payload(p);
                    else                           req[p] = 1'b0;
                end else if (req[p]) begin
                    if ($urandom_range(0, 15) == 0) req[p] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_payload(p);
                end
            end
        end
        m_gnt   = 1'($urandom_range(0, 1));
        m_rvld  = ($urandom_range(0, 2) == 0);
        m_rdata = $urandom;
    endtask

    initial begin
        rst     = 1'b1;
        m_gnt   = 1'b0;
        m_rvld  = 1'b0;
        m_rdata = 32'h0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; add[p] = 32'h0; wdata[p] = 32'h0; be[p] = 4'h0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            evaluate();
            @(posedge clk);
            #1;
            drive_next();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_sb_arbiter.md
DM_SB_ARBITER -- requirements
Module: dm_sb_arbiter

Interface
REQ-001 The block SHALL have parameter BusWidth, default 32, meaning data/address width, 32 or 64.
REQ-002 The block SHALL have parameter TimeoutCycles, default 256, meaning response-wait cycles before a timeout error; 0 disables the timeout.
REQ-003 The block SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have ports m0_req_i, m0_we_i (input, 1), m0_add_i, m0_wdata_i (input, BusWidth) and m0_be_i (input, BusWidth/8), meaning the system-bus-access requester (port 0).
REQ-006 The block SHALL have ports m0_gnt_o, m0_r_valid_o, m0_r_err_o (output, 1) and m0_r_rdata_o (output, BusWidth), meaning the port 0 grant and response.
REQ-007 The block SHALL have ports m1_* identical to m0_*, meaning the abstract-command memory requester (port 1).
REQ-008 The block SHALL have ports master_req_o, master_we_o (output, 1), master_add_o, master_wdata_o (output, BusWidth), master_be_o (output, BusWidth/8), master_gnt_i, master_r_valid_i (input, 1) and master_r_rdata_i (input, BusWidth), meaning the shared downstream bus.
REQ-009 The block SHALL have port busy_o, output, 1, meaning the state is not Idle.

Function
REQ-010 Protocol: the requester SHALL hold req and its payload until gnt, and each grant SHALL produce exactly one r_valid, no earlier than the cycle after gnt; at most one transaction is outstanding.
REQ-011 States SHALL be Idle, Req and Wait; owner SHALL be a 1-bit register naming the port being served.
REQ-012 In Idle, if any req_i is high, the arbitration winner's payload SHALL be forwarded to master_* combinationally in the same cycle, with master_req_o=1.
REQ-013 In Idle, if master_gnt_i is high in that cycle, the arbiter SHALL assert the winner's gnt_o, latch owner and go to Wait; otherwise it SHALL latch owner and go to Req.
REQ-014 In Req, the owner's request SHALL be forwarded regardless of the other port, so the selection is stable until granted; on master_gnt_i it SHALL assert the owner's gnt_o and go to Wait.
REQ-015 In Req, if the owner's req_i drops before grant, the arbiter SHALL return to Idle with no grant issued.
REQ-016 In Wait, master_req_o SHALL be 0; on master_r_valid_i it SHALL drive the owner's r_valid_o=1, r_rdata_o=master_r_rdata_i, r_err_o=0, and go to Idle.
REQ-017 The non-owner's gnt_o and r_valid_o SHALL always be 0; r_rdata_o of both ports SHALL mirror master_r_rdata_i.
REQ-018 Timeout: the counter SHALL clear on entry to Wait and increment each Wait cycle; if it reaches TimeoutCycles without r_valid, the arbiter SHALL drive the owner's r_valid_o=1, r_err_o=1, r_rdata_o='0, and go to Idle.
REQ-019 If r_valid and timeout coincide, r_valid SHALL win and r_err_o SHALL be 0.
REQ-020 A master_r_valid_i arriving in Idle or Req SHALL be ignored: no requester response is produced.
REQ-021 When neither port requests in Idle, master_req_o SHALL be 0 and master_add_o, master_wdata_o and master_be_o SHALL be '0.

Reset
REQ-022 While rst_i is high at a clock edge, state SHALL become Idle, owner 0, counter 0 and the round-robin pointer 0, and all *_gnt_o, *_r_valid_o, *_r_err_o and master_req_o SHALL be 0 the following cycle.
REQ-023 A reset asserted mid-transaction SHALL abandon it without a response, and a later stray r_valid SHALL be ignored per REQ-020.

Configuration
REQ-024 With macro DM_SB_ARBITER_RR_EN defined, Idle arbitration SHALL be round-robin: a 1-bit pointer names the preferred port and, on each grant, is set to the port not granted.
REQ-025 Without DM_SB_ARBITER_RR_EN, arbitration SHALL be fixed priority with port 0 highest, and no pointer register SHALL exist.

Verification
REQ-026 Single read: m0 requests add=0x1000 while master_gnt_i=1 the same cycle, and r_valid follows 2 cycles later with 0xDEADBEEF -> m0_gnt_o=1 in the request cycle; m0_r_valid_o=1 with 0xDEADBEEF and err=0; m1 sees nothing.
REQ-027 Simultaneous requests m0 add=0x10 and m1 add=0x20, both repeated back-to-back -> fixed priority grants only m0; with RR_EN, grants alternate m0, m1, m0.
REQ-028 Stall: m1 requests while master_gnt_i is low for 3 cycles and m0 requests in cycle 2 -> master_add_o holds m1's address until grant; m0 is not granted until m1's response returns.
REQ-029 Timeout with TimeoutCycles=4: grant, then no r_valid -> owner's r_valid_o=1 and r_err_o=1 exactly 4 cycles after entering Wait; a late r_valid is ignored.
REQ-030 Reset: rst_i pulsed during Wait, then master_r_valid_i=1 -> busy_o=0 after reset; no r_valid_o on either port.
